// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for the 7-segment digit bank.
// Latency: registered outputs; the first digit appears on the edge after enable is seen in IDLE.
// Backpressure: none; free-running scan, and enable low parks the controller blank in IDLE.
//
// Build option: SEG_SCAN_LEADING_ZERO_BLANK_EN blanks leading zero digits at snapshot time.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset
//   i_enable       scan enable
//   i_digits_in    packed BCD digits, digit i at [4*i+3:4*i], digit 0 rightmost
//   i_dots_in      dot flag per digit
//   o_bcd          BCD code to the shared decoder, 4'hF = blank
//   o_dot          dot bit to the decoder
//   o_digit_sel    one-hot active-high digit enable, all zero while blank
//   o_frame_done   one-cycle pulse after the last digit's blank slot
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_digits_in,
  input  logic [NUM_DIGITS-1:0]   i_dots_in,
  output logic [3:0]              o_bcd,
  output logic                    o_dot,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_done
);

  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  localparam logic [CW-1:0] P_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] B_LAST   = HAS_BLANK ? CW'(BLANK_CYCLES - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_snap;
  logic [NUM_DIGITS-1:0]   r_snap_dot;

  logic [4*NUM_DIGITS-1:0] w_snap_next;
  logic                    w_show_done;
  logic                    w_blank_done;
  logic                    w_slot_end;
  logic                    w_idx_last;
  logic                    w_go_show;
  logic                    w_go_blank;
  logic                    w_go_idle;
  logic                    w_resnap;
  logic                    w_fdone;
  logic [IW-1:0]           w_show_idx;
  logic [3:0]              w_bcd_nxt;
  logic                    w_dot_nxt;
  logic [NUM_DIGITS-1:0]   w_sel_nxt;

  // Snapshot value. With leading-zero blanking, zeros without a dot are
  // replaced by the blank code from the most significant digit down until the
  // first significant digit; digit 0 always shows so "0" stays visible.
  always_comb begin : snap_build
    w_snap_next = i_digits_in;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    begin : lz_blank
      logic v_lead;
      v_lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        if (v_lead && (i_digits_in[4*i +: 4] == 4'd0) && !i_dots_in[i]) begin
          w_snap_next[4*i +: 4] = 4'hF;
        end else begin
          v_lead = 1'b0;
        end
      end
    end
`endif
  end

  assign w_show_done  = (r_state == ST_SHOW)  && (r_cnt == P_LAST);
  assign w_blank_done = (r_state == ST_BLANK) && (r_cnt == B_LAST);
  // Without a blanking gap the slot ends directly at the end of SHOW.
  assign w_slot_end   = HAS_BLANK ? w_blank_done : w_show_done;
  assign w_idx_last   = (r_idx == IDX_LAST);

  // Transition decision. The frame-end edge takes priority over an enable
  // drop so the final frame still reports frame_done before going idle;
  // any other edge with enable low aborts the frame silently.
  always_comb begin
    w_go_show  = 1'b0;
    w_go_blank = 1'b0;
    w_go_idle  = 1'b0;
    w_resnap   = 1'b0;
    w_fdone    = 1'b0;
    w_show_idx = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_go_show  = 1'b1;
          w_resnap   = 1'b1;
          w_show_idx = '0;
        end
      end
      ST_SHOW, ST_BLANK: begin
        if (w_slot_end && w_idx_last) begin
          w_fdone = 1'b1;
          if (i_enable) begin
            w_go_show  = 1'b1;
            w_resnap   = 1'b1;
            w_show_idx = '0;
          end else begin
            w_go_idle = 1'b1;
          end
        end else if (!i_enable) begin
          w_go_idle = 1'b1;
        end else if (w_slot_end) begin
          w_go_show  = 1'b1;
          w_show_idx = r_idx + IW'(1);
        end else if (w_show_done) begin
          w_go_blank = 1'b1;
        end
      end
      default: begin
        w_go_idle = 1'b1;
      end
    endcase
  end

  // Digit presented on entry to SHOW; a fresh snapshot is forwarded directly
  // so digit 0 of a new frame shows on the same edge that captures it.
  always_comb begin
    w_bcd_nxt = 4'hF;
    w_dot_nxt = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_show_idx == IW'(i)) begin
        w_bcd_nxt = w_resnap ? w_snap_next[4*i +: 4] : r_snap[4*i +: 4];
        w_dot_nxt = w_resnap ? i_dots_in[i] : r_snap_dot[i];
      end
    end
  end

  assign w_sel_nxt = NUM_DIGITS'(1) << w_show_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_snap       <= '0;
      r_snap_dot   <= '0;
      o_bcd        <= 4'hF;
      o_dot        <= 1'b0;
      o_digit_sel  <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= w_fdone;
      if (w_resnap) begin
        r_snap     <= w_snap_next;
        r_snap_dot <= i_dots_in;
      end
      if (w_go_show) begin
        r_state     <= ST_SHOW;
        r_cnt       <= '0;
        r_idx       <= w_show_idx;
        o_bcd       <= w_bcd_nxt;
        o_dot       <= w_dot_nxt;
        o_digit_sel <= w_sel_nxt;
      end else if (w_go_blank) begin
        r_state     <= ST_BLANK;
        r_cnt       <= '0;
        o_bcd       <= 4'hF;
        o_dot       <= 1'b0;
        o_digit_sel <= '0;
      end else if (w_go_idle) begin
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_idx       <= '0;
        o_bcd       <= 4'hF;
        o_dot       <= 1'b0;
        o_digit_sel <= '0;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the watch's 7-segment display bank.
- Snapshots NUM_DIGITS packed BCD digits and dot flags at each frame start.
- Presents one digit at a time as the 4-bit BCD code and dot input for the shared BCD-to-segment decoder, and drives the matching one-hot digit-select line.
- Inserts a blanking gap between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 6: number of digits scanned (HH MM SS).
- PRESCALE, 1000: clock cycles each digit is driven (>=1).
- BLANK_CYCLES, 16: clock cycles all digits are off between slots. 0 means no gap.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  scanning enabled.
- digits_in  input  4*NUM_DIGITS  packed BCD; digit i = digits_in[4*i+3:4*i]; digit 0 is rightmost.
- dots_in  input  NUM_DIGITS  dot flag per digit; bit i belongs to digit i.
- bcd  output  4  BCD code to the decoder; 4'b1111 = blank (the decoder maps it to all segments off).
- dot  output  1  dot bit to the decoder.
- digit_sel  output  NUM_DIGITS  one-hot, active-high digit enable. All zeros when blank.
- frame_done  output  1  one-cycle pulse after the last digit's BLANK slot.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values: bcd=4'b1111, dot=0, digit_sel=0, frame_done=0. State IDLE, idx=0, slot counter=0, snapshot registers=0.
- Registered outputs: all outputs are registered and change on the same edge that enters a state.
- States:
  - IDLE: outputs blank. If enable=1, capture digits_in/dots_in into the snapshot, set idx=0, enter SHOW.
  - SHOW: digit_sel=1<<idx, bcd=snap[idx], dot=snap_dot[idx]. Held exactly PRESCALE cycles, then enter BLANK. If BLANK_CYCLES=0, go directly to the next-slot decision.
  - BLANK: digit_sel=0, bcd=4'b1111, dot=0. Held exactly BLANK_CYCLES cycles.
- Next-slot decision (end of BLANK, or end of SHOW when BLANK_CYCLES=0):
  - If idx<NUM_DIGITS-1: idx+1, enter SHOW.
  - Otherwise: frame_done=1 for that one cycle and idx wraps to 0.
    - If enable=1: re-snapshot the inputs and enter SHOW, with no extra cycle.
    - If enable=0: enter IDLE.
- Frame period: NUM_DIGITS*(PRESCALE+BLANK_CYCLES) cycles, continuous while enable stays high.
- Input changes: changes on digits_in/dots_in mid-frame are invisible until the next snapshot, so there is no tearing.
- enable deasserted in SHOW or BLANK: the next edge enters IDLE with blank outputs, idx=0, counter cleared, and no frame_done.
- rst mid-frame: on the next edge, everything returns to its reset values.
- Invalid BCD codes (10-15) pass through unchanged; the decoder blanks them.
- Slot counter width: $clog2(max(PRESCALE,BLANK_CYCLES)+1). It reloads to 0 at each state entry.
- digit_sel never has more than one bit set in any cycle.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined: at snapshot time, scan from digit NUM_DIGITS-1 downward. Each digit equal to 0 with its dot clear is stored as 4'b1111 until the first digit that is nonzero or has its dot set. Digit 0 is never blanked. digit_sel timing is unchanged, so blanked digits still occupy their slot.
- Undefined: the snapshot stores digits verbatim.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2 unless noted):
- Reset then enable=1, digits_in=16'h1234, dots_in=4'b0100:
  - SHOW order gives bcd 4,3,2,1 with digit_sel 0001,0010,0100,1000.
  - dot=1 only while digit_sel=0100.
  - Each SHOW lasts 4 cycles, followed by 2 blank cycles (bcd=F, sel=0).
  - frame_done pulses once every 24 cycles.
- digits_in changed from 16'h1234 to 16'h9999 during digit 1 -> the remainder of the frame still shows 3,2,1; the next frame shows 9,9,9,9.
- enable dropped during the SHOW of digit 2 -> next edge: sel=0, bcd=F, no frame_done. Re-enable -> restarts at digit 0 with a fresh snapshot.
- rst asserted mid-BLANK -> next edge: all outputs at reset values, state IDLE.
- BLANK_CYCLES=0, PRESCALE=1 -> digit_sel rotates every cycle with no gap, and frame_done pulses every 4 cycles.
- With SEG_SCAN_LEADING_ZERO_BLANK_EN defined:
  - digits_in=16'h0070 -> bcd F,F,7,0 shown for digits 3,2,1,0.
  - digits_in=16'h0000 -> only digit 0 shows 0.
  - dots_in=4'b0100 with digits_in=16'h0000 -> digit 3 shows F; digits 2,1,0 show 0.
